// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, FSM states and opcode
// classification helpers.
package alu_arb_pkg;

  localparam logic [8:0] OP_ADD  = 9'h000;
  localparam logic [8:0] OP_SUB  = 9'h001;
  localparam logic [8:0] OP_MUL  = 9'h002;
  localparam logic [8:0] OP_DIV  = 9'h003;
  localparam logic [8:0] OP_MOD  = 9'h004;
  localparam logic [8:0] OP_AND  = 9'h005;
  localparam logic [8:0] OP_OR   = 9'h006;
  localparam logic [8:0] OP_XOR  = 9'h007;
  localparam logic [8:0] OP_NOT  = 9'h008;
  localparam logic [8:0] OP_SHL  = 9'h009;
  localparam logic [8:0] OP_SHR  = 9'h00A;
  localparam logic [8:0] OP_SRA  = 9'h00B;
  localparam logic [8:0] OP_MOVA = 9'h00C;
  localparam logic [8:0] OP_MOVB = 9'h00D;
  localparam logic [8:0] OP_INC  = 9'h00E;
  localparam logic [8:0] OP_DEC  = 9'h00F;
  localparam logic [8:0] OP_NOOP = 9'h080;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_t;

  function automatic logic is_legal(input logic [8:0] op);
    return op <= OP_DEC;
  endfunction

  function automatic logic is_div(input logic [8:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 with wrap and
// returns a one-hot grant plus its index.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           hit
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    pos = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!hit && req[pos]) begin
        hit      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-latency ALU between NREQ
// requesters; one operation in flight, results returned with requester ID.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 65,
  parameter int IW   = 9,
  parameter int IDW  = 3
) (
  input  logic                 c,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IW-1:0]   req_op,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [IW-1:0]        alu_instr,
  input  logic [DW-1:0]        alu_out
);

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [IW-1:0]  alu_instr_q, alu_instr_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_hit;
  logic [IW-1:0]   sel_op;
  logic [DW-1:0]   sel_a, sel_b;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .hit  (gnt_hit)
  );

  assign sel_op = req_op[int'(gnt_idx)*IW +: IW];
  assign sel_a  = req_a[int'(gnt_idx)*DW +: DW];
  assign sel_b  = req_b[int'(gnt_idx)*DW +: DW];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_instr_d = alu_instr_q;
    req_ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_hit && !rst) begin
          req_ready = gnt;
          last_d    = gnt_idx;
          rsp_id_d  = gnt_idx;
          // Screened ops never touch the ALU; they answer straight from RESP.
          if (!is_legal(sel_op) || (is_div(sel_op) && sel_b == '0)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            alu_a_d     = sel_a;
            alu_b_d     = sel_b;
            alu_instr_d = sel_op;
            state_d     = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        alu_instr_d = IW'(OP_NOOP);
        state_d     = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_data_d  = alu_out;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Error path arrives with rsp_valid low and raises it one edge later.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(NREQ - 1);
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= IW'(OP_NOOP);
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_instr_q <= alu_instr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_instr = alu_instr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub plus scenario tasks checked
// against a reference model of the arbitration and response rules.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 65;
  localparam int IW   = 9;
  localparam int IDW  = 3;

  logic                c = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*IW-1:0]  req_op;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [IW-1:0]       alu_instr;
  logic [DW-1:0]       alu_out = '0;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW), .IDW(IDW)) dut (
    .c         (c),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_instr (alu_instr),
    .alu_out   (alu_out)
  );

  always #5 c = ~c;

  function automatic logic [64:0] alu_fn(input logic [8:0] op, input logic [64:0] a,
                                         input logic [64:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == '0) ? '0 : a / b;
      OP_MOD:  return (b == '0) ? '0 : a % b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return a << b[5:0];
      OP_SHR:  return a >> b[5:0];
      OP_SRA:  return 65'($signed(a) >>> b[5:0]);
      OP_MOVA: return a;
      OP_MOVB: return b;
      OP_INC:  return a + 65'd1;
      OP_DEC:  return a - 65'd1;
      default: return a;
    endcase
  endfunction

  // ALU stub: result registered on the clock edge, NOOP holds the output
  always @(posedge c) begin
    if (alu_instr != OP_NOOP) alu_out <= alu_fn(alu_instr, alu_a, alu_b);
  end

  task automatic step();
    @(posedge c);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [64:0] rnd65();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[64:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    step();
    step();
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_id} !== '0) begin
      errors++; $display("FAIL reset_rsp_ctrl: got valid=%b err=%b id=%0d want 0", rsp_valid, rsp_err, rsp_id);
    end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    checks++;
    if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu_ab: got a=%h b=%h want 0", alu_a, alu_b); end
    checks++;
    if (alu_instr !== 9'h080) begin errors++; $display("FAIL reset_alu_instr: got %h want 080", alu_instr); end
    rst = 1'b0;
    req_valid = '0;
    step();
  endtask

  // Single transaction from one requester, checked against model rules.
  task automatic run_op(input int id, input logic [8:0] op, input logic [64:0] a,
                        input logic [64:0] b, input int hold);
    logic            exp_err;
    logic [64:0]     exp_data;
    logic [NREQ-1:0] exp_rdy;
    int              exp_lat;
    int              lat;
    exp_err  = (op > 9'h00F) || ((op == 9'h003 || op == 9'h004) && b == '0);
    exp_data = exp_err ? 65'd0 : alu_fn(op, a, b);
    exp_lat  = exp_err ? 1 : 2;
    exp_rdy  = '0;
    exp_rdy[id] = 1'b1;
    req_op[id*IW +: IW] = op;
    req_a[id*DW +: DW]  = a;
    req_b[id*DW +: DW]  = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b0;
    #1;
    lat = 0;
    while (req_ready == '0 && lat < 8) begin step(); #1; lat++; end
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++; $display("FAIL grant op=%h: got %b want %b", op, req_ready, exp_rdy);
    end
    step();
    req_valid = '0;
    #1;
    checks++;
    if (alu_instr !== (exp_err ? 9'h080 : op)) begin
      errors++; $display("FAIL alu_issue op=%h: got %h want %h", op, alu_instr, exp_err ? 9'h080 : op);
    end
    if (!exp_err) begin
      checks++;
      if (alu_a !== a || alu_b !== b) begin
        errors++; $display("FAIL alu_operands: got a=%h b=%h want a=%h b=%h", alu_a, alu_b, a, b);
      end
    end
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      step(); #1; lat++;
      if (lat == 1) begin
        checks++;
        if (alu_instr !== 9'h080) begin errors++; $display("FAIL alu_noop_e1: got %h want 080", alu_instr); end
      end
    end
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL latency op=%h: got %0d want %0d", op, lat, exp_lat); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, IDW'(id), exp_err, exp_data}) begin
      errors++;
      $display("FAIL response op=%h: got v=%b id=%0d err=%b data=%h want v=1 id=%0d err=%b data=%h",
               op, rsp_valid, rsp_id, rsp_err, rsp_data, id, exp_err, exp_data);
    end
    for (int h = 0; h < hold; h++) begin
      step(); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, IDW'(id), exp_err, exp_data}) begin
        errors++; $display("FAIL hold_stable: got v=%b id=%0d err=%b data=%h", rsp_valid, rsp_id, rsp_err, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_single_add();
    run_op(0, OP_ADD, 65'd5, 65'd7, 0);
  endtask

  task automatic test_errors();
    run_op(1, OP_DIV, 65'd9, 65'd0, 1);
    run_op(0, OP_MOD, 65'd9, 65'd0, 0);
    run_op(0, 9'h010, 65'd3, 65'd4, 0);
    run_op(1, 9'h080, 65'd3, 65'd4, 0);
    run_op(1, OP_DIV, 65'd9, 65'd2, 0);
  endtask

  task automatic test_fairness();
    int exp_g;
    int n;
    logic [64:0] exp_d;
    do_reset();
    req_op = {OP_ADD, OP_ADD};
    req_a  = {65'd10, 65'd1};
    req_b  = {65'd20, 65'd2};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = k % 2;
      exp_d = (exp_g == 0) ? 65'd3 : 65'd30;
      #1;
      n = 0;
      while (req_ready == '0 && n < 8) begin step(); #1; n++; end
      checks++;
      if (req_ready !== 2'(1 << exp_g)) begin
        errors++; $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, 2'(1 << exp_g));
      end
      step(); #1;
      n = 0;
      while (!rsp_valid && n < 6) begin step(); #1; n++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_g) || rsp_data !== exp_d) begin
        errors++; $display("FAIL fair_rsp%0d: got v=%b id=%0d data=%h want id=%0d data=%h",
                           k, rsp_valid, rsp_id, rsp_data, exp_g, exp_d);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    req_op = {OP_ADD, OP_MUL};
    req_a  = {65'd100, 65'd6};
    req_b  = {65'd23, 65'd7};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0: got %b want 01", req_ready); end
    step();
    req_valid = 2'b10;
    #1;
    n = 0;
    while (!rsp_valid && n < 6) begin
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_busy_ready: got %b want 00", req_ready); end
      step(); #1; n++;
    end
    for (int h = 0; h < 5; h++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 65'd42 || rsp_id !== 3'd0 || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b data=%h id=%0d rdy=%b want v=1 data=2a id=0 rdy=00",
                           h, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      step(); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake_ready: got %b want 00", req_ready); end
    step();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_after: got v=%b rdy=%b want v=0 rdy=10", rsp_valid, req_ready);
    end
    step();
    req_valid = '0;
    #1;
    n = 0;
    while (!rsp_valid && n < 6) begin step(); #1; n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_data !== 65'd123) begin
      errors++; $display("FAIL bp_req1: got v=%b id=%0d data=%h want id=1 data=7b", rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    logic seen;
    do_reset();
    req_op[0 +: IW] = OP_SUB;
    req_a[0 +: DW]  = 65'd100;
    req_b[0 +: DW]  = 65'd1;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rx_grant: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (alu_instr !== 9'h080 || alu_a !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++; $display("FAIL rx_state: got instr=%h a=%h v=%b data=%h want 080/0/0/0",
                         alu_instr, alu_a, rsp_valid, rsp_data);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rx_no_rsp: got rsp_valid after reset, want none"); end
    req_op[IW +: IW] = OP_ADD;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rx_regrant: got %b want 01", req_ready); end
    req_valid = '0;
    step();
    do_reset();
  endtask

  task automatic test_random();
    int          id;
    int          sel;
    logic [8:0]  op;
    logic [64:0] a;
    logic [64:0] b;
    for (int k = 0; k < 24; k++) begin
      id  = int'($urandom_range(0, NREQ - 1));
      sel = int'($urandom_range(0, 7));
      a   = rnd65();
      b   = ($urandom_range(0, 1) == 0) ? rnd65() : 65'($urandom_range(1, 40));
      case (sel)
        5:       begin op = 9'($urandom_range(3, 4)); b = '0; end
        6:       op = 9'($urandom_range(16, 511));
        7:       op = OP_NOOP;
        default: op = 9'($urandom_range(0, 15));
      endcase
      run_op(id, op, a, b, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_errors();
    test_fairness();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
